// File: rtl/demux16b5_router.sv
// ============================================================================
//  Module      : demux16b5_router
//  Description : Single-entry 1-to-5 demultiplexing router. A word accepted
//                on the input is loaded into the data register of the port
//                named by in_set and presented there with a valid flag until
//                that port's consumer takes it. Words addressed to a
//                nonexistent port (in_set 5..7) are discarded, and each
//                discard is reported by a one-cycle drop pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    in_data    in   WIDTH  word to route
//    in_set     in   3      destination port (0..4 valid, 5..7 invalid)
//    in_valid   in   1      in_data / in_set valid this cycle
//    in_ready   out  1      router accepts the word this cycle
//    out0..out4 out  WIDTH  per-port data registers
//    out_valid  out  5      bit k: outk holds an undelivered word
//    out_ready  in   5      bit k: consumer k takes outk this cycle
//    drop       out  1      pulse: an invalid-port word was discarded
//    err_count  out  8      saturating discard counter (optional)
//
//  Build option
//    DEMUX16B5_ERRCNT_EN : when defined, adds the err_count port and the
//                          saturating 8-bit discard counter behind it.
// ============================================================================
`default_nettype none

module demux16b5_router #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_set,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
`ifdef DEMUX16B5_ERRCNT_EN
  output logic [7:0]       err_count,
`endif
  output logic             drop
);

  localparam int NPORTS = 5;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_out [NPORTS];
  logic             r_drop;

  logic             w_sel_ready;
  logic             w_accept;
  logic             w_set_ok;
  logic             w_xfer_out;
  logic [4:0]       w_out_valid;
  logic [4:0]       w_load;

  // Readiness of the consumer currently addressed by the held word. r_sel
  // only ever holds 0..4, but the full 3-bit range is decoded so that no
  // out-of-range vector index is ever formed.
  always_comb begin
    w_sel_ready = 1'b0;
    case (r_sel)
      3'd0:    w_sel_ready = out_ready[0];
      3'd1:    w_sel_ready = out_ready[1];
      3'd2:    w_sel_ready = out_ready[2];
      3'd3:    w_sel_ready = out_ready[3];
      3'd4:    w_sel_ready = out_ready[4];
      default: w_sel_ready = 1'b0;
    endcase
  end

  // in_ready depends only on registered state and out_ready, never on
  // in_valid. When full, a new word is taken only in the cycle the held word
  // leaves, so the single entry is never overwritten.
  assign in_ready = (r_state == ST_EMPTY) || w_sel_ready;
  assign w_accept = in_valid && in_ready;
  assign w_set_ok = (in_set <= 3'd4);

  generate
    for (genvar k = 0; k < NPORTS; k++) begin : g_port
      assign w_out_valid[k] = (r_state == ST_FULL) && (r_sel == 3'(k));
      assign w_load[k]      = w_accept && (in_set == 3'(k));
    end
  endgenerate

  assign w_xfer_out = |(w_out_valid & out_ready);

  // Control state. A valid acceptance always leaves the router full (even if
  // the old word leaves in the same cycle); otherwise a delivery empties it.
  // An accepted invalid word leaves the state alone except for any delivery
  // happening in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_sel   <= 3'd0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_accept && !w_set_ok;
      if (w_accept && w_set_ok) begin
        r_state <= ST_FULL;
        r_sel   <= in_set;
      end else if (w_xfer_out) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  // Per-port data registers: each one changes only when a word addressed to
  // its own port is accepted, so unselected ports keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPORTS; k++) begin
        r_out[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (w_load[k]) begin
          r_out[k] <= in_data;
        end
      end
    end
  end

`ifdef DEMUX16B5_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Counts on the same edge that raises drop; holds at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && !w_set_ok && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

  assign out0      = r_out[0];
  assign out1      = r_out[1];
  assign out2      = r_out[2];
  assign out3      = r_out[3];
  assign out4      = r_out[4];
  assign out_valid = w_out_valid;
  assign drop      = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_demux16b5_router.sv
// ============================================================================
//  Module      : tb_demux16b5_router
//  Description : Table-driven self-checking bench for demux16b5_router, plus
//                hand-written sequences for reset-while-full and discard
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux16b5_router;

  localparam int WIDTH = 16;
  localparam int NVEC  = 22;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_set;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0, out1, out2, out3, out4;
  logic [4:0]       out_valid;
  logic [4:0]       out_ready;
  logic             drop;
`ifdef DEMUX16B5_ERRCNT_EN
  logic [7:0]       err_count;
`endif

  int checks;
  int failures;

  demux16b5_router #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_set    (in_set),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX16B5_ERRCNT_EN
    .err_count (err_count),
`endif
    .drop      (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [2:0]  set;
    logic [15:0] data;
    logic [4:0]  ordy;
    logic        exp_rdy;
    logic [4:0]  exp_ov;
    logic        exp_drop;
    logic [79:0] exp_outs;   // {out4,out3,out2,out1,out0}
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(logic v, logic [2:0] set, logic [15:0] data,
                              logic [4:0] ordy, logic rdy, logic [4:0] ov,
                              logic drp, logic [15:0] o0, logic [15:0] o1,
                              logic [15:0] o2, logic [15:0] o3,
                              logic [15:0] o4);
    vec_t r;
    r.v = v; r.set = set; r.data = data; r.ordy = ordy;
    r.exp_rdy = rdy; r.exp_ov = ov; r.exp_drop = drp;
    r.exp_outs = {o4, o3, o2, o1, o0};
    return r;
  endfunction

  task automatic chk(input string name, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return {out4, out3, out2, out1, out0};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    //          v  set   data      ordy      rdy  ov        drp out0     out1     out2     out3     out4
    tbl[0]  = mk(1, 3'd0, 16'h0001, 5'b11111, 1, 5'b00001, 0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 3'd1, 16'h0003, 5'b11111, 1, 5'b00010, 0, 16'h0001, 16'h0003, 16'h0000, 16'h0000, 16'h0000);
    tbl[2]  = mk(1, 3'd2, 16'h0007, 5'b11111, 1, 5'b00100, 0, 16'h0001, 16'h0003, 16'h0007, 16'h0000, 16'h0000);
    tbl[3]  = mk(1, 3'd3, 16'h000F, 5'b11111, 1, 5'b01000, 0, 16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h0000);
    tbl[4]  = mk(1, 3'd4, 16'h001F, 5'b11111, 1, 5'b10000, 0, 16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F);
    // held word on port 2 while its consumer stalls
    tbl[5]  = mk(1, 3'd2, 16'hA5A5, 5'b11111, 1, 5'b00100, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[6]  = mk(1, 3'd0, 16'h1234, 5'b00000, 0, 5'b00100, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[7]  = mk(0, 3'd0, 16'h0000, 5'b00000, 0, 5'b00100, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[8]  = mk(0, 3'd0, 16'h0000, 5'b00000, 0, 5'b00100, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[9]  = mk(0, 3'd1, 16'hFFFF, 5'b00000, 0, 5'b00100, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[10] = mk(0, 3'd0, 16'h0000, 5'b00100, 1, 5'b00000, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[11] = mk(0, 3'd3, 16'h9999, 5'b00000, 1, 5'b00000, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    // invalid destinations back-to-back
    tbl[12] = mk(1, 3'd5, 16'hFFFF, 5'b00000, 1, 5'b00000, 1, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[13] = mk(1, 3'd6, 16'hEEEE, 5'b00000, 1, 5'b00000, 1, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[14] = mk(1, 3'd7, 16'hDDDD, 5'b00000, 1, 5'b00000, 1, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[15] = mk(0, 3'd5, 16'h0000, 5'b00000, 1, 5'b00000, 0, 16'h0001, 16'h0003, 16'hA5A5, 16'h000F, 16'h001F);
    // delivery and new acceptance in the same cycle
    tbl[16] = mk(1, 3'd1, 16'hBEEF, 5'b00000, 1, 5'b00010, 0, 16'h0001, 16'hBEEF, 16'hA5A5, 16'h000F, 16'h001F);
    tbl[17] = mk(1, 3'd4, 16'h4444, 5'b00010, 1, 5'b10000, 0, 16'h0001, 16'hBEEF, 16'hA5A5, 16'h000F, 16'h4444);
    tbl[18] = mk(1, 3'd4, 16'h5555, 5'b10000, 1, 5'b10000, 0, 16'h0001, 16'hBEEF, 16'hA5A5, 16'h000F, 16'h5555);
    tbl[19] = mk(1, 3'd0, 16'h0A0A, 5'b10000, 1, 5'b00001, 0, 16'h0A0A, 16'hBEEF, 16'hA5A5, 16'h000F, 16'h5555);
    // invalid word accepted while the held word leaves
    tbl[20] = mk(1, 3'd5, 16'h7777, 5'b00001, 1, 5'b00000, 1, 16'h0A0A, 16'hBEEF, 16'hA5A5, 16'h000F, 16'h5555);
    tbl[21] = mk(0, 3'd0, 16'h0000, 5'b00000, 1, 5'b00000, 0, 16'h0A0A, 16'hBEEF, 16'hA5A5, 16'h000F, 16'h5555);

    rst_n     = 1'b0;
    in_data   = '0;
    in_set    = '0;
    in_valid  = 1'b0;
    out_ready = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 80'h0);
    chk("reset_out_valid", {75'h0, out_valid}, 80'h0);
    chk("reset_drop", {79'h0, drop}, 80'h0);
`ifdef DEMUX16B5_ERRCNT_EN
    chk("reset_err_count", {72'h0, err_count}, 80'h0);
`endif
    rst_n = 1'b1;

    // First vector is driven right after release, so it lands on the first
    // rising edge with rst_n high.
    for (int i = 0; i < NVEC; i++) begin
      in_valid  = tbl[i].v;
      in_set    = tbl[i].set;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("in_ready[%0d]", i), {79'h0, in_ready}, {79'h0, tbl[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("out_valid[%0d]", i), {75'h0, out_valid}, {75'h0, tbl[i].exp_ov});
      chk($sformatf("drop[%0d]", i), {79'h0, drop}, {79'h0, tbl[i].exp_drop});
      chk($sformatf("outs[%0d]", i), outs(), tbl[i].exp_outs);
`ifdef DEMUX16B5_ERRCNT_EN
      if (i == 14) chk("err_count_after_3", {72'h0, err_count}, 80'd3);
`endif
      @(negedge clk);
    end
`ifdef DEMUX16B5_ERRCNT_EN
    chk("err_count_after_table", {72'h0, err_count}, 80'd4);
`endif

    // Reset pulsed while holding a word for port 3.
    in_valid  = 1'b1;
    in_set    = 3'd3;
    in_data   = 16'h3333;
    out_ready = 5'b00000;
    @(posedge clk);
    #1;
    chk("full_port3_valid", {75'h0, out_valid}, 80'b01000);
    chk("full_port3_data", {64'h0, out3}, 80'h3333);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 80'h0);
    chk("async_reset_valid", {75'h0, out_valid}, 80'h0);
    chk("async_reset_drop", {79'h0, drop}, 80'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 5'b11111;
    #1;
    chk("post_reset_in_ready", {79'h0, in_ready}, 80'h1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_no_delivery[%0d]", c), {75'h0, out_valid}, 80'h0);
    end

    // 300 consecutive invalid words.
    @(negedge clk);
    in_valid = 1'b1;
    in_set   = 3'd6;
    in_data  = 16'hCAFE;
    repeat (300) @(posedge clk);
    #1;
    chk("drop_sustained", {79'h0, drop}, 80'h1);
    chk("outs_after_invalid_burst", outs(), 80'h0);
`ifdef DEMUX16B5_ERRCNT_EN
    chk("err_count_saturated", {72'h0, err_count}, 80'd255);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_ends", {79'h0, drop}, 80'h0);
`ifdef DEMUX16B5_ERRCNT_EN
    chk("err_count_holds", {72'h0, err_count}, 80'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
